sr_alu_mul_seq: RTL and testbench

SR_ALU_MUL_SEQ -- requirements
Module: sr_alu_mul_seq

---
 rtl/sr_alu_mul_seq.sv | 165 ++++++++++++++++
 tb/tb_sr_alu_mul_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// sr_alu_mul_seq
// Sequential 32x32 -> 32 (low half, unsigned) shift-add multiplier that does
// no arithmetic of its own: every add and shift is issued, one per cycle, to
// a shared sr_alu through the alu_* ports.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start_valid  request valid       start_ready  high only in IDLE
//   op_a/op_b    multiplicand/multiplier, captured on accept
//   res_valid    product available (DONE only)
//   res_ready    consumer accepts product
//   res_data     low 32 bits of op_a*op_b (tracks the accumulator)
//   busy         state != IDLE
//   alu_srcA/B, alu_oper  drive the shared ALU
//   alu_result, alu_zero  returned by the shared ALU
//
// Configuration macro: SR_MUL_SEQ_EARLY_EXIT_EN
//   defined   : finish as soon as the remaining multiplier is zero
//   undefined : always run all 32 iterations (alu_zero ignored)
// -----------------------------------------------------------------------------
module sr_alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [2:0]  alu_oper,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  // Encodings shared with the CPU's ALU decoder.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SRL = 3'b010;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    DBL  = 3'd2,
    SHR  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;

  state_t      w_state_next;
  logic [31:0] w_acc_next;
  logic [31:0] w_mcand_next;
  logic [31:0] w_mplier_next;
  logic [4:0]  w_cnt_next;

`ifndef SR_MUL_SEQ_EARLY_EXIT_EN
  // Zero flag only matters for early exit.
  logic w_unused_alu_zero;
  assign w_unused_alu_zero = alu_zero;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 5'd0;
    end else begin
      r_state  <= w_state_next;
      r_acc    <= w_acc_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_cnt    <= w_cnt_next;
    end
  end

  // Next state, datapath loads and ALU drive. The ALU operands are a pure
  // function of the current state so the shared ALU sees one op per cycle.
  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    w_cnt_next    = r_cnt;
    alu_oper      = ALU_ADD;
    alu_srcA      = 32'd0;
    alu_srcB      = 32'd0;

    case (r_state)
      IDLE: begin
        if (start_valid) begin
          w_acc_next    = 32'd0;
          w_mcand_next  = op_a;
          w_mplier_next = op_b;
          w_cnt_next    = 5'd0;
`ifdef SR_MUL_SEQ_EARLY_EXIT_EN
          if (op_b == 32'd0)
            w_state_next = DONE;
          else
`endif
          w_state_next = op_b[0] ? ACC : DBL;
        end
      end

      // acc += mcand for a set multiplier bit
      ACC: begin
        alu_srcA     = r_acc;
        alu_srcB     = r_mcand;
        w_acc_next   = alu_result;
        w_state_next = DBL;
      end

      // mcand <<= 1, done as mcand + mcand
      DBL: begin
        alu_srcA     = r_mcand;
        alu_srcB     = r_mcand;
        w_mcand_next = alu_result;
        w_state_next = SHR;
      end

      // mplier >>= 1; the new LSB selects the next iteration's path
      SHR: begin
        alu_oper      = ALU_SRL;
        alu_srcA      = r_mplier;
        alu_srcB      = 32'd1;
        w_mplier_next = alu_result;
        w_cnt_next    = r_cnt + 5'd1;
        if (r_cnt == 5'd31)
          w_state_next = DONE;
`ifdef SR_MUL_SEQ_EARLY_EXIT_EN
        else if (alu_zero)
          w_state_next = DONE;
`endif
        else
          w_state_next = alu_result[0] ? ACC : DBL;
      end

      DONE: begin
        if (res_ready)
          w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign start_ready = (r_state == IDLE);
  assign res_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign res_data    = r_acc;

endmodule

// File: tb/tb_sr_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_sr_alu_mul_seq
// Directed bench for sr_alu_mul_seq with a behavioural model of the shared ALU.
// Build with +define+SR_MUL_SEQ_EARLY_EXIT_EN to exercise the early-exit build.
// -----------------------------------------------------------------------------
module tb_sr_alu_mul_seq;

`ifdef SR_MUL_SEQ_EARLY_EXIT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [2:0]  alu_oper;
  logic [31:0] alu_result;
  logic        alu_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_alu_mul_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .alu_srcA    (alu_srcA),
    .alu_srcB    (alu_srcB),
    .alu_oper    (alu_oper),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  // Shared ALU model (ADD=000, OR=001, SRL=010, SLTU=011, SUB=100).
  always_comb begin
    case (alu_oper)
      3'b000:  alu_result = alu_srcA + alu_srcB;
      3'b001:  alu_result = alu_srcA | alu_srcB;
      3'b010:  alu_result = alu_srcA >> alu_srcB[4:0];
      3'b011:  alu_result = {31'd0, (alu_srcA < alu_srcB)};
      3'b100:  alu_result = alu_srcA - alu_srcB;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs are sampled and
  // inputs driven here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply with res_ready=1. exp_cyc is the number of cycles spent in
  // ACC/DBL/SHR (busy and no result yet).
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc);
    int n;
    int cyc;
    n = 0;
    while (!start_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_ready"}, {31'd0, start_ready}, 32'd1);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    res_ready   = 1'b1;
    tick();                       // accept edge
    start_valid = 1'b0;
    op_a        = 32'hDEAD_BEEF;  // captured values must not track inputs
    op_b        = 32'hDEAD_BEEF;
    cyc = 0;
    while (!res_valid && cyc < 200) begin
      if (busy) cyc++;
      tick();
    end
    check_eq({tag, "_res"}, res_data, exp_res);
    check_eq({tag, "_cyc"}, cyc, exp_cyc);
    tick();                       // handshake edge
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin : main
    int n;
    int k;
    int cyc;
    int n_acc;
    int n_hs;
    int acc_edge [3];
    int hs_edge  [2];
    logic [31:0] hs_data [2];
    logic a_now;
    logic h_now;
    logic [31:0] d_now;

    rst         = 1'b1;
    start_valid = 1'b0;
    op_a        = 32'd0;
    op_b        = 32'd0;
    res_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check_eq("rst_res_valid",   {31'd0, res_valid},   32'd0);
    check_eq("rst_busy",        {31'd0, busy},        32'd0);
    check_eq("rst_res_data",    res_data,             32'd0);
    check_eq("rst_alu_oper",    {29'd0, alu_oper},    32'd0);
    check_eq("rst_alu_srcA",    alu_srcA,             32'd0);
    check_eq("rst_alu_srcB",    alu_srcB,             32'd0);

    // Directed products; cycles = 64+popcount(b) or early-exit count
    do_mul("m3x5",      32'd3,          32'd5,          32'd15,         EN ? 8  : 66);
    do_mul("mffx2",     32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  EN ? 5  : 65);
    do_mul("m10kx10k",  32'h0001_0000,  32'h0001_0000,  32'd0,          EN ? 35 : 65);
    do_mul("mbzero",    32'd12345,      32'd0,          32'd0,          EN ? 0  : 64);
    do_mul("mffxff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          96);
    do_mul("m1000sq",   32'd1000,       32'd1000,       32'd1000000,    EN ? 26 : 70);

    // Hold DONE with res_ready low; new requests must be ignored
    start_valid = 1'b1;
    op_a        = 32'd6;
    op_b        = 32'd7;
    res_ready   = 1'b0;
    tick();
    start_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'b1;
      op_a        = 32'd100 + i;
      op_b        = 32'd3;
      check_eq("hold_valid", {31'd0, res_valid},   32'd1);
      check_eq("hold_data",  res_data,             32'd42);
      check_eq("hold_ready", {31'd0, start_ready}, 32'd0);
      tick();
    end
    check_eq("hold_end_valid", {31'd0, res_valid}, 32'd1);
    check_eq("hold_end_data",  res_data,           32'd42);
    start_valid = 1'b0;
    res_ready   = 1'b1;
    tick();
    check_eq("hold_release_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of 7*9 (res_ready low so DONE is held if reached)
    res_ready   = 1'b0;
    start_valid = 1'b1;
    op_a        = 32'd7;
    op_b        = 32'd9;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check_eq("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_busy",        {31'd0, busy},        32'd0);
    check_eq("midrst_res_valid",   {31'd0, res_valid},   32'd0);
    check_eq("midrst_start_ready", {31'd0, start_ready}, 32'd1);
    check_eq("midrst_res_data",    res_data,             32'd0);
    do_mul("m7x9", 32'd7, 32'd9, 32'd63, EN ? 10 : 66);

    // Back-to-back with start_valid held high
    start_valid = 1'b1;
    op_a        = 32'd3;
    op_b        = 32'd5;
    res_ready   = 1'b1;
    cyc   = 0;
    n_acc = 0;
    n_hs  = 0;
    acc_edge = '{-1, -1, -1};
    hs_edge  = '{-1, -1};
    hs_data  = '{32'd0, 32'd0};
    k = 0;
    while (k < 400 && n_hs < 2) begin
      a_now = start_valid && start_ready;
      h_now = res_valid && res_ready;
      d_now = res_data;
      tick();
      cyc++;
      k++;
      if (a_now && n_acc < 3) begin
        acc_edge[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          op_a = 32'd4;
          op_b = 32'd6;
        end else begin
          start_valid = 1'b0;
        end
      end
      if (h_now) begin
        hs_edge[n_hs] = cyc;
        hs_data[n_hs] = d_now;
        n_hs++;
      end
    end
    start_valid = 1'b0;
    check_eq("b2b_num_results", n_hs,       32'd2);
    check_eq("b2b_first",       hs_data[0], 32'd15);
    check_eq("b2b_second",      hs_data[1], 32'd24);
    check_eq("b2b_accept_gap",  acc_edge[1] - hs_edge[0], 32'd1);
    check_eq("b2b_num_accepts", n_acc,      32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
